// File: rtl/detector_seq_pkg.sv
// Shared types and default sizing for the sequence-detector sequencing controller.
package detector_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DefDiv  = 4;
  localparam int unsigned DefPatW = 8;
  localparam int unsigned DefCntW = 4;

endpackage

// File: rtl/tick_gen.sv
// Divide-by-DIV enable generator: a one-clk tick every DIV enabled cycles, no derived clock.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == Last);

endmodule

// File: rtl/detector_seq_ctrl.sv
// Sequencing controller: clears the detector, shifts a latched pattern into it one bit per
// divided tick, counts detector hits and pulses done at the end of the run.
module detector_seq_ctrl
  import detector_seq_pkg::*;
#(
  parameter int unsigned DIV   = DefDiv,
  parameter int unsigned PAT_W = DefPatW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic             det_y,
  output logic             tick,
  output logic             x,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] det_count
);

  localparam int unsigned IdxW = $clog2(PAT_W + 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_en, div_clr, tick_int;

  assign div_en  = (state_q == StShift);
  assign div_clr = (state_q == StLoad);

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .clr (div_clr),
    .tick(tick_int)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          sr_d    = pattern;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      StLoad: state_d = StShift;
      StShift: begin
        if (tick_int) begin
          // det_y is the Mealy output for the bit currently on x.
          if (det_y && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          sr_d  = sr_q << 1;
          idx_d = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign tick      = tick_int;
  assign det_clr   = div_clr;
  assign busy      = (state_q == StLoad) || (state_q == StShift);
  assign done      = (state_q == StDone);
  assign x         = busy ? sr_q[PAT_W-1] : 1'b0;
  assign det_count = cnt_q;

endmodule

// File: tb/tb_detector_seq_ctrl.sv
// Scoreboard bench: driver pushes expected ticks/clear/done per run, a negedge monitor pops them.
module tb_detector_seq_ctrl;
  import detector_seq_pkg::*;

  localparam int unsigned DIV   = 4;
  localparam int unsigned PAT_W = 8;
  localparam int unsigned CNT_W = 3;
  localparam int CntMax = (1 << CNT_W) - 1;
  localparam int RunLen = PAT_W * DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic             det_y;
  logic             tick, x, det_clr, busy, done;
  logic [CNT_W-1:0] det_count;

  always #5 clk = ~clk;

  detector_seq_ctrl #(
    .DIV  (DIV),
    .PAT_W(PAT_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .det_y    (det_y),
    .tick     (tick),
    .x        (x),
    .det_clr  (det_clr),
    .busy     (busy),
    .done     (done),
    .det_count(det_count)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Detector environment: 0 = "110" Mealy detector, 1 = tied high, 2 = per-tick mask, 3 = tied low
  int               mode = 3;
  logic [PAT_W-1:0] mask = '0;
  logic [1:0]       hist = 2'b00;
  int               tk = 0;
  logic             noise = 1'b0;

  always @(posedge clk) begin
    noise <= 1'($urandom_range(0, 1));
    if (det_clr) begin
      hist <= 2'b00;
      tk   <= 0;
    end else if (tick) begin
      hist <= {hist[0], x};
      tk   <= tk + 1;
    end
  end

  always_comb begin
    det_y = 1'b0;
    case (mode)
      0: det_y = (hist == 2'b11) && !x;
      1: det_y = 1'b1;
      2: det_y = tick ? ((tk < PAT_W) ? mask[PAT_W-1-tk] : 1'b0) : noise;
      default: det_y = 1'b0;
    endcase
  end

  // Reference: detections from the bit stream alone, then saturate.
  function automatic int ref_count(input logic [PAT_W-1:0] p, input int md,
                                   input logic [PAT_W-1:0] m);
    int n;
    n = 0;
    for (int k = 0; k < PAT_W; k++) begin
      case (md)
        0: if (k >= 2) begin
             if (p[PAT_W+1-k] && p[PAT_W-k] && !p[PAT_W-1-k]) n++;
           end
        1: n++;
        2: if (m[PAT_W-1-k]) n++;
        default: ;
      endcase
    end
    return (n > CntMax) ? CntMax : n;
  endfunction

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  int   exp_tick_cyc[$];
  logic exp_tick_x[$];
  int   exp_clr_cyc[$];
  int   exp_done_cyc[$];
  int   exp_done_cnt[$];
  int   busy_lo = -1;
  int   busy_hi = -2;
  bit   mon_on = 1'b0;
  int   mon_c;
  logic mon_x;

  always @(negedge clk) begin
    if (mon_on) begin
      check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
      if (!busy) check("x_when_idle", int'(x), 0);
      if (tick) begin
        if (exp_tick_cyc.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          mon_c = exp_tick_cyc.pop_front();
          mon_x = exp_tick_x.pop_front();
          check("tick_cycle", cyc, mon_c);
          check("tick_x", int'(x), int'(mon_x));
        end
      end
      if (det_clr) begin
        if (exp_clr_cyc.size() == 0) check("unexpected_det_clr", 1, 0);
        else check("det_clr_cycle", cyc, exp_clr_cyc.pop_front());
      end
      if (done) begin
        if (exp_done_cyc.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cycle", cyc, exp_done_cyc.pop_front());
          check("done_count", int'(det_count), exp_done_cnt.pop_front());
        end
      end
    end
  end

  // Entered and left just after a negedge; start is raised in the entry cycle s.
  task automatic run(input logic [PAT_W-1:0] p, input int md, input logic [PAT_W-1:0] m,
                     input bit hold, input bit poke, input int rst_at);
    int s, ec;
    s  = cyc;
    ec = ref_count(p, md, m);
    start   = 1'b1;
    pattern = p;
    mode    = md;
    mask    = m;
    busy_lo = s + 1;
    busy_hi = s + 1 + RunLen;
    exp_clr_cyc.push_back(s + 1);
    for (int k = 1; k <= PAT_W; k++) begin
      exp_tick_cyc.push_back(s + 1 + k * DIV);
      exp_tick_x.push_back(p[PAT_W-k]);
    end
    exp_done_cyc.push_back(s + 2 + RunLen);
    exp_done_cnt.push_back(ec);
    for (int i = 1; i <= RunLen + 3; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (!hold) start = 1'b0;
        pattern = PAT_W'($urandom);
      end
      if (poke && (i == 10 || i == RunLen + 2)) start = 1'b1;
      if (poke && i == 11) start = 1'b0;
      if (rst_at > 0 && i == rst_at) begin
        rst = 1'b0;
        exp_tick_cyc.delete();
        exp_tick_x.delete();
        exp_done_cyc.delete();
        exp_done_cnt.delete();
        busy_hi = s + rst_at;
      end
      if (rst_at > 0 && i == rst_at + 1) begin
        check("reset_count", int'(det_count), 0);
        check("reset_done", int'(done), 0);
      end
      if (rst_at > 0 && i == rst_at + 2) rst = 1'b1;
      if (i == RunLen + 3) begin
        if (!hold) start = 1'b0;
        check("count_hold", int'(det_count), (rst_at > 0) ? 0 : ec);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_x", int'(x), 0);
    check("rst_det_clr", int'(det_clr), 0);
    check("rst_count", int'(det_count), 0);
    rst    = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);

    run(8'b10110110, 0, '0, 1'b0, 1'b0, 0);
    run(8'hFF, 1, '0, 1'b0, 1'b0, 0);
    run(PAT_W'($urandom), 0, '0, 1'b0, 1'b1, 0);
    run(PAT_W'($urandom), 2, PAT_W'($urandom), 1'b1, 1'b0, 0);
    run(PAT_W'($urandom), 0, '0, 1'b0, 1'b0, 0);
    run(PAT_W'($urandom), 2, PAT_W'($urandom), 1'b0, 1'b0, 15);
    run(8'h00, 3, '0, 1'b0, 1'b0, 0);
    for (int r = 0; r < 8; r++) begin
      run(PAT_W'($urandom), int'($urandom_range(0, 2)), PAT_W'($urandom), 1'b0, 1'b0, 0);
    end
    repeat (4) @(negedge clk);

    check("leftover_ticks", exp_tick_cyc.size(), 0);
    check("leftover_clr", exp_clr_cyc.size(), 0);
    check("leftover_done", exp_done_cyc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/detector_seq_ctrl.md
# detector_seq_ctrl

Sequencing controller for the lab's serial sequence-detector datapath (divided-clock FSM flops plus Mealy output). It replaces the free-running clock divider and test-pattern source with one synchronous controller. On a start request it clears the detector, then shifts a latched test pattern into it one bit per divided tick. It samples the detector output on each tick, counts detections, and signals completion.

## Interface
Parameters:
- DIV, 4: system clocks per detector tick; legal range ≥ 2.
- PAT_W, 8: test pattern length in bits.
- CNT_W, 4: detection counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  run request; sampled only in IDLE.
- pattern  in  PAT_W  test pattern; latched on an accepted start; shifted MSB first.
- det_y  in  1  detector output Y; sampled on tick cycles.
- tick  out  1  one-clk enable for the detector state flops.
- x  out  1  serial stimulus bit to the detector.
- det_clr  out  1  active-high one-cycle clear of the detector state flops.
- busy  out  1  high in LOAD and SHIFT.
- done  out  1  one-cycle completion pulse.
- det_count  out  CNT_W  detections in the current or last run.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE → LOAD when start=1. On this transition:
  - latch pattern into the shift register;
  - clear the bit index and det_count.
- LOAD lasts one cycle. It asserts det_clr=1 and clears the divider counter, then goes to SHIFT.
- SHIFT:
  - Divider counts 0..DIV-1 and wraps; tick=1 only when the divider counter equals DIV-1.
  - On a tick cycle:
    - if det_y=1, det_count increments, saturating at 2^CNT_W-1;
    - the shift register shifts left;
    - the bit index increments.
  - After the PAT_W-th tick, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- x = shift register MSB in LOAD and SHIFT, and 0 otherwise. x is stable for the whole tick period and changes only in the cycle after a tick.
- start outside IDLE is ignored, including in DONE. pattern changes after acceptance have no effect.
- det_count holds its final value after DONE until the next accepted start.
- Reset:
  - rst=0 forces IDLE and zeroes all registers, the divider and the count.
  - Outputs read 0 in the cycle after the reset edge.
  - This applies in any state; a reset mid-run produces no done pulse.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: LOAD, det_clr=1, busy=1. Cycle 2: first SHIFT cycle, divider=0.
- k-th tick (k=1..PAT_W) occurs at cycle 1+k·DIV.
- done=1 at cycle 2+PAT_W·DIV; busy is 0 in that cycle.
- IDLE at cycle 3+PAT_W·DIV. A start held high is accepted there, so the next LOAD is at cycle 4+PAT_W·DIV.
- det_count updates in the cycle after each counted tick. The final value is visible when done=1.
- All outputs are registered, except tick and det_clr, which are decoded from registered state and counter only.

## Structure
- Shared package `detector_seq_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE);
  - default DIV, PAT_W and CNT_W constants.
- One sub-module, `tick_gen`:
  - DIV-period counter with a synchronous clear input;
  - emits the one-clk tick;
  - replaces the standalone clock divider, so there is no derived clock.
- The top holds the FSM, shift register, bit index and saturating counter.

## Test plan
1. Reset: rst=0 for 2 cycles from an arbitrary state → busy=done=tick=x=det_clr=0 and det_count=0 from the next cycle.
2. DIV=4, PAT_W=8, pattern=8'b10110110, bench Mealy model flags "110", start at cycle 0:
   - det_clr at cycle 1;
   - ticks at cycles 5, 9, …, 33 with x=1,0,1,1,0,1,1,0;
   - done at cycle 34 with det_count=2.
3. CNT_W=3, det_y tied 1, pattern=8'hFF → 8 ticks; det_count saturates at 7, no wrap.
4. start pulsed at cycle 10 during a run, and again during DONE → ignored. Then start held high continuously → next LOAD at cycle 36, back-to-back runs.
5. rst=0 at cycle 15 mid-SHIFT → IDLE at cycle 16; det_count=0, x=0; no done pulse, no further ticks.
6. pattern=8'h00, det_y=0 → exactly 8 ticks, x=0 throughout, det_count=0, done at cycle 34.
